hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum data-memory wait cycles before the error state.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 Resetn  input  1  reset, synchronous, active-low.
REQ-004 id_rs1  input  5  source register 1 of the instruction in ID.
REQ-005 id_rs2  input  5  source register 2 of the instruction in ID.
REQ-006 id_use  input  2  bit0/bit1: the ID instruction reads rs1/rs2.
REQ-007 ex_rs1  input  5  source register 1 of the instruction in EX.
REQ-008 ex_rs2  input  5  source register 2 of the instruction in EX.
REQ-009 ex_rd  input  5  destination of the instruction in EX.
REQ-010 ex_regwr  input  1  the EX instruction writes the regfile.
REQ-011 ex_memread  input  1  the EX instruction is a load.
REQ-012 mem_rd  input  5  destination of the instruction in MEM.
REQ-013 mem_regwr  input  1  the MEM instruction writes the regfile.
REQ-014 wb_rd  input  5  destination of the instruction in WB.
REQ-015 wb_regwr  input  1  the WB instruction writes the regfile.
REQ-016 mem_req  input  1  the MEM stage is accessing data memory.
REQ-017 mem_ack  input  1  data memory completes the access this cycle.
REQ-018 br_redirect  input  1  branch taken or jump resolved in EX.
REQ-019 pc_en  output  1  enable for the PC and the IF/ID register.
REQ-020 idex_en  output  1  enable for the ID/EX register.
REQ-021 back_en  output  1  enable for the EX/MEM and MEM/WB registers.
REQ-022 ifid_flush  output  1  load a NOP into IF/ID.
REQ-023 idex_flush  output  1  load a NOP bubble into ID/EX.
REQ-024 fwd_a  output  2  ALU A source: 00 regfile, 10 MEM, 01 WB.
REQ-025 fwd_b  output  2  ALU B source; same encoding as fwd_a.
REQ-026 mem_err  output  1  sticky flag: memory timeout.
REQ-027 stall_cnt  output  16  saturating count of stalled cycles.

Function
REQ-028 FSM states: RUN, MWAIT, ERR. RUN->MWAIT on mem_req&!mem_ack. MWAIT->RUN on mem_ack. MWAIT->ERR when wait counter reaches TIMEOUT. ERR is held until reset.
REQ-029 The wait counter (8 bits) clears on entry to MWAIT and increments on each cycle spent in MWAIT.
REQ-030 Freeze condition = (RUN&mem_req&!mem_ack) | MWAIT | ERR. Under freeze, pc_en=idex_en=back_en=0 and both flushes are 0.
REQ-031 Load-use condition = ex_memread & ex_rd!=0 & ((id_use[0]&id_rs1==ex_rd)|(id_use[1]&id_rs2==ex_rd)). Response: pc_en=0, idex_flush=1, back_en=1.
REQ-032 Redirect (br_redirect, not frozen): ifid_flush=1, idex_flush=1, pc_en=1. Load-use is ignored in the same cycle.
REQ-033 Priority: freeze > redirect > load-use > normal. Normal: all enables 1, all flushes 0.
REQ-034 Forwarding: fwd_x=10 if mem_regwr & mem_rd!=0 & mem_rd==ex_rsx; else 01 if the same test matches on WB; else 00. MEM wins over WB.
REQ-035 stall_cnt increments on every cycle with pc_en=0 and saturates at 16'hFFFF.
REQ-036 Enables and flushes are combinational from the current state and inputs. State, counters and mem_err are registered.

Reset
REQ-037 While Resetn=0 at a clock edge: state=RUN, wait counter=0, stall_cnt=0, mem_err=0.
REQ-038 While Resetn=0: pc_en=idex_en=back_en=0, ifid_flush=idex_flush=1, fwd_a=fwd_b=00. Reset mid-MWAIT abandons the access.

Configuration
REQ-039 Macro HAZARD_FORWARD_EN.
- Defined: behaviour as REQ-031/034.
- Undefined: fwd_a=fwd_b=00 constantly. The load-use condition is widened to any ID source matching ex_rd (ex_regwr) or mem_rd (mem_regwr), with rd!=0. WB is covered by the write-first regfile.

Structure
REQ-040 Shared package holds the FSM state typedef, the fwd encodings (FWD_RF, FWD_MEM, FWD_WB) and TIMEOUT_DEFAULT.
REQ-041 One sub-module, hazard_fwd_unit, is natural: the combinational REQ-034 comparator for one operand, instantiated twice.

Verification
REQ-042 ex_memread=1, ex_rd=5, id_rs1=5, id_use=01 -> pc_en=0, idex_flush=1; stall_cnt increments by 1.
REQ-043 mem_regwr=1, mem_rd=3, wb_regwr=1, wb_rd=3, ex_rs2=3 -> fwd_b=10. With mem_rd=0 instead -> fwd_b=01.
REQ-044 mem_req=1, mem_ack=0 for 4 cycles, then ack -> freeze for 4 cycles, RUN on the next cycle, stall_cnt=4.
REQ-045 TIMEOUT=3, mem_ack held 0 -> ERR entered, mem_err=1, pipeline frozen until Resetn=0.
REQ-046 br_redirect=1 together with a load-use match -> ifid_flush=idex_flush=1, pc_en=1. With mem_req&!mem_ack also set -> freeze wins.
REQ-047 HAZARD_FORWARD_EN undefined, ex_regwr=1, ex_rd=7, id_rs2=7, id_use=10 -> stall; fwd_a=fwd_b=00.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM states, forwarding-mux encodings, pipeline control bundles and a source-match helper.
package hazard_ctrl_pkg;

   localparam int TIMEOUT_DEFAULT = 255;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_MWAIT = 2'b01,
      ST_ERR   = 2'b10
   } hz_state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   typedef struct packed {
      logic pc_en;
      logic idex_en;
      logic back_en;
      logic ifid_flush;
      logic idex_flush;
   } pipe_ctl_t;

   localparam pipe_ctl_t CTL_RESET    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   localparam pipe_ctl_t CTL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam pipe_ctl_t CTL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   localparam pipe_ctl_t CTL_LOAD_USE = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   localparam pipe_ctl_t CTL_NORMAL   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

   // True when a source actually read by the ID instruction names a non-zero rd being written.
   function automatic logic src_match(input logic [1:0] src_use,
                                      input logic [4:0] rs1,
                                      input logic [4:0] rs2,
                                      input logic [4:0] rd,
                                      input logic       wr);
      return wr && (rd != 5'd0) &&
             ((src_use[0] && (rs1 == rd)) || (src_use[1] && (rs2 == rd)));
   endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forwarding comparator for one ALU operand: MEM-stage result wins over WB-stage result.
module hazard_fwd_unit
   import hazard_ctrl_pkg::*;
(
   input  logic [4:0] ex_rs,
   input  logic [4:0] mem_rd,
   input  logic       mem_regwr,
   input  logic [4:0] wb_rd,
   input  logic       wb_regwr,
   output logic [1:0] fwd
);

   // Operand source select from the younger-first producer match.
   always_comb begin
      fwd = FWD_RF;
      if (mem_regwr && (mem_rd != 5'd0) && (mem_rd == ex_rs)) begin
         fwd = FWD_MEM;
      end else if (wb_regwr && (wb_rd != 5'd0) && (wb_rd == ex_rs)) begin
         fwd = FWD_WB;
      end else begin
         fwd = FWD_RF;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze FSM, redirect/load-use handling, forwarding.
// Build option: define HAZARD_FORWARD_EN to enable operand forwarding; otherwise hazards stall.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
)
(
   input  logic        clk,
   input  logic        Resetn,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [1:0]  id_use,
   input  logic [4:0]  ex_rs1,
   input  logic [4:0]  ex_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_regwr,
   input  logic        ex_memread,
   input  logic [4:0]  mem_rd,
   input  logic        mem_regwr,
   input  logic [4:0]  wb_rd,
   input  logic        wb_regwr,
   input  logic        mem_req,
   input  logic        mem_ack,
   input  logic        br_redirect,
   output logic        pc_en,
   output logic        idex_en,
   output logic        back_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic        mem_err,
   output logic [15:0] stall_cnt
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   hz_state_t   state_r;
   logic [7:0]  wait_cnt_r;
   logic [15:0] stall_cnt_r;
   logic        mem_err_r;

   logic        freeze_s;
   logic        load_use_s;
   pipe_ctl_t   ctl_s;
   logic [1:0]  fwd_a_s;
   logic [1:0]  fwd_b_s;
   logic        fwd_unused_s;

   hazard_fwd_unit u_fwd_a (
      .ex_rs     (ex_rs1),
      .mem_rd    (mem_rd),
      .mem_regwr (mem_regwr),
      .wb_rd     (wb_rd),
      .wb_regwr  (wb_regwr),
      .fwd       (fwd_a_s)
   );

   hazard_fwd_unit u_fwd_b (
      .ex_rs     (ex_rs2),
      .mem_rd    (mem_rd),
      .mem_regwr (mem_regwr),
      .wb_rd     (wb_rd),
      .wb_regwr  (wb_regwr),
      .fwd       (fwd_b_s)
   );

   // Freeze decode; the MWAIT cycle that sees mem_ack advances so the returned data is captured.
   always_comb begin
      freeze_s = 1'b1;
      case (state_r)
         ST_RUN:   freeze_s = mem_req && !mem_ack;
         ST_MWAIT: freeze_s = !mem_ack;
         ST_ERR:   freeze_s = 1'b1;
         default:  freeze_s = 1'b1;
      endcase
   end

   // Load-use detect; without forwarding any in-flight producer in EX or MEM must stall ID.
   always_comb begin
      load_use_s   = 1'b0;
      fwd_unused_s = 1'b0;
`ifdef HAZARD_FORWARD_EN
      load_use_s   = src_match(id_use, id_rs1, id_rs2, ex_rd, ex_memread);
      fwd_unused_s = ex_regwr;
`else
      load_use_s   = src_match(id_use, id_rs1, id_rs2, ex_rd, ex_memread) ||
                     src_match(id_use, id_rs1, id_rs2, ex_rd, ex_regwr)   ||
                     src_match(id_use, id_rs1, id_rs2, mem_rd, mem_regwr);
      fwd_unused_s = ^{fwd_a_s, fwd_b_s};
`endif
   end

   // Pipeline enables/flushes by priority: reset, freeze, redirect, load-use, normal.
   always_comb begin
      ctl_s = CTL_RESET;
      if (!Resetn) begin
         ctl_s = CTL_RESET;
      end else if (freeze_s) begin
         ctl_s = CTL_FREEZE;
      end else if (br_redirect) begin
         ctl_s = CTL_REDIRECT;
      end else if (load_use_s) begin
         ctl_s = CTL_LOAD_USE;
      end else begin
         ctl_s = CTL_NORMAL;
      end
   end

   // Forwarding mux selects, forced to the regfile path in reset and when forwarding is absent.
   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (!Resetn) begin
         fwd_a = FWD_RF;
         fwd_b = FWD_RF;
      end else begin
`ifdef HAZARD_FORWARD_EN
         fwd_a = fwd_a_s;
         fwd_b = fwd_b_s;
`else
         fwd_a = FWD_RF;
         fwd_b = FWD_RF;
`endif
      end
   end

   // Memory-wait FSM with wait/stall counters and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (!Resetn) begin
         state_r     <= ST_RUN;
         wait_cnt_r  <= 8'd0;
         stall_cnt_r <= 16'd0;
         mem_err_r   <= 1'b0;
      end else begin
         if (!ctl_s.pc_en && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
         end
         case (state_r)
            ST_RUN: begin
               if (mem_req && !mem_ack) begin
                  state_r    <= ST_MWAIT;
                  wait_cnt_r <= 8'd0;
               end
            end
            ST_MWAIT: begin
               if (mem_ack) begin
                  state_r <= ST_RUN;
               end else if (wait_cnt_r == TIMEOUT_CNT) begin
                  state_r   <= ST_ERR;
                  mem_err_r <= 1'b1;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 8'd1;
               end
            end
            ST_ERR: begin
               state_r <= ST_ERR;
            end
            default: begin
               state_r <= ST_RUN;
            end
         endcase
      end
   end

   assign pc_en      = ctl_s.pc_en;
   assign idex_en    = ctl_s.idex_en;
   assign back_en    = ctl_s.back_en;
   assign ifid_flush = ctl_s.ifid_flush;
   assign idex_flush = ctl_s.idex_flush;
   assign mem_err    = mem_err_r;
   assign stall_cnt  = stall_cnt_r;

endmodule
